// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_pkg
// Purpose  : Shared types and constants for the ALU instruction sequencer:
//            FSM state encoding, operand shift codes, ALU op codes and the
//            latched instruction record.
// Revision : 1.0  initial release
// ============================================================================
package alu_seq_pkg;

  // Datapath and register-file geometry
  localparam int REG_W    = 16;
  localparam int RF_DEPTH = 8;
  localparam int ADDR_W   = 3;

  // Sequencer states; one instruction visits all five in order
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ_A = 3'd1,
    ST_READ_B = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WRITE  = 3'd4
  } state_e;

  // Operand-B shift codes
  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL1 = 2'b01;
  localparam logic [1:0] SH_LSR1 = 2'b10;
  localparam logic [1:0] SH_ASR1 = 2'b11;

  // Op codes understood by the external ALU
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_NOTB = 2'b11;

  // Instruction fields captured at the handshake
  typedef struct packed {
    logic [1:0]        op;
    logic [ADDR_W-1:0] rd;
    logic [ADDR_W-1:0] rn;
    logic [ADDR_W-1:0] rm;
    logic [1:0]        shift;
    logic              cmp;
  } instr_t;

endpackage : alu_seq_pkg
`default_nettype wire

// File: rtl/shifter16.sv
`default_nettype none
// ============================================================================
// Module   : shifter16
// Purpose  : Single-position operand shifter applied to operand B:
//            pass-through, logical left, logical right or arithmetic right.
// Revision : 1.0  initial release
// ============================================================================
module shifter16
  import alu_seq_pkg::*;
(
  input  logic [REG_W-1:0] din_i,
  input  logic [1:0]       sh_i,
  output logic [REG_W-1:0] dout_o
);

  // Select one of the four shifted views of the input word
  always_comb begin
    dout_o = din_i;
    case (sh_i)
      SH_NONE: dout_o = din_i;
      SH_LSL1: dout_o = {din_i[REG_W-2:0], 1'b0};
      SH_LSR1: dout_o = {1'b0, din_i[REG_W-1:1]};
      SH_ASR1: dout_o = {din_i[REG_W-1], din_i[REG_W-1:1]};
      default: dout_o = din_i;
    endcase
  end

endmodule : shifter16
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer
// Purpose  : Five-state instruction sequencer around an external ALU.
//            Reads two operands from an 8 x 16 register file (operand B
//            optionally shifted), presents them to the ALU, captures the
//            result and flags, and writes the result back unless the
//            instruction is a compare. One instruction per five cycles.
// Revision : 1.0  initial release
// ============================================================================
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  // instruction handshake and fields
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [1:0]        alu_op,
  input  logic [ADDR_W-1:0] rd,
  input  logic [ADDR_W-1:0] rn,
  input  logic [ADDR_W-1:0] rm,
  input  logic [1:0]        shift,
  input  logic              cmp,
  // external register-file load
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [REG_W-1:0]  wr_data,
  // downstream ALU
  output logic [REG_W-1:0]  alu_ain,
  output logic [REG_W-1:0]  alu_bin,
  output logic [1:0]        alu_opc,
  input  logic [REG_W-1:0]  alu_out,
  input  logic              alu_z,
  input  logic              alu_n,
  input  logic              alu_v,
  // results
  output logic [REG_W-1:0]  result,
  output logic [2:0]        status,
  output logic              done
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e             state_q;
  instr_t             instr_q;
  logic [REG_W-1:0]   a_q;
  logic [REG_W-1:0]   b_q;
  logic [REG_W-1:0]   c_q;
  logic [2:0]         status_q;
  logic               done_q;
  logic               ready_q;
  logic [REG_W-1:0]   rf_q [RF_DEPTH];

  // Register-file write port, shared by external load and writeback
  logic               rf_we_d;
  logic [ADDR_W-1:0]  rf_waddr_d;
  logic [REG_W-1:0]   rf_wdata_d;

  // Read ports and shifted operand B
  logic [REG_W-1:0]   rf_rn_data;
  logic [REG_W-1:0]   rf_rm_data;
  logic [REG_W-1:0]   b_shifted;
  logic               handshake;

  assign handshake  = instr_valid && ready_q;
  assign rf_rn_data = rf_q[instr_q.rn];
  assign rf_rm_data = rf_q[instr_q.rm];

  shifter16 u_shifter (
    .din_i  (rf_rm_data),
    .sh_i   (instr_q.shift),
    .dout_o (b_shifted)
  );

  // --------------------------------------------------------------------------
  // Register-file write arbitration. The two sources never collide: external
  // loads are only honoured in IDLE and writeback only happens in WRITE.
  // --------------------------------------------------------------------------
  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = wr_addr;
    rf_wdata_d = wr_data;
    if ((state_q == ST_IDLE) && wr_en) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = wr_addr;
      rf_wdata_d = wr_data;
    end else if ((state_q == ST_WRITE) && !instr_q.cmp) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = instr_q.rd;
      rf_wdata_d = c_q;
    end
  end

  // Register file storage, cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RF_DEPTH; i++) begin
        rf_q[i] <= '0;
      end
    end else if (rf_we_d) begin
      rf_q[rf_waddr_d] <= rf_wdata_d;
    end
  end

  // --------------------------------------------------------------------------
  // Sequencer FSM with operand/result registers and registered handshake
  // outputs. A and B are only ever loaded in their read states, so the ALU
  // inputs stay stable outside EXEC instead of dropping to zero.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      instr_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      status_q <= 3'b000;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (handshake) begin
            instr_q.op    <= alu_op;
            instr_q.rd    <= rd;
            instr_q.rn    <= rn;
            instr_q.rm    <= rm;
            instr_q.shift <= shift;
            instr_q.cmp   <= cmp;
            ready_q       <= 1'b0;
            state_q       <= ST_READ_A;
          end
        end
        ST_READ_A: begin
          a_q     <= rf_rn_data;
          state_q <= ST_READ_B;
        end
        ST_READ_B: begin
          b_q     <= b_shifted;
          state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          c_q      <= alu_out;
          status_q <= {alu_z, alu_n, alu_v};
          done_q   <= 1'b1;
          state_q  <= ST_WRITE;
        end
        ST_WRITE: begin
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign instr_ready = ready_q;
  assign alu_ain     = a_q;
  assign alu_bin     = b_q;
  assign alu_opc     = instr_q.op;
  assign result      = c_q;
  assign status      = status_q;
  assign done        = done_q;

endmodule : alu_sequencer
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_sequencer
// Purpose  : Self-checking bench for alu_sequencer. Provides the external
//            ALU, a transaction-level reference model, directed scenarios
//            with literal expectations and a randomized phase.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [1:0]  alu_op = 2'b00;
  logic [2:0]  rd = 3'd0, rn = 3'd0, rm = 3'd0;
  logic [1:0]  shift = 2'b00;
  logic        cmp = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = 3'd0;
  logic [15:0] wr_data = 16'h0;
  logic [15:0] alu_ain, alu_bin, alu_out;
  logic [1:0]  alu_opc;
  logic        alu_z, alu_n, alu_v;
  logic [15:0] result;
  logic [2:0]  status;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .alu_op(alu_op), .rd(rd), .rn(rn), .rm(rm), .shift(shift), .cmp(cmp),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alu_ain(alu_ain), .alu_bin(alu_bin), .alu_opc(alu_opc),
    .alu_out(alu_out), .alu_z(alu_z), .alu_n(alu_n), .alu_v(alu_v),
    .result(result), .status(status), .done(done)
  );

  // ALU behaviour: returns {Z, N, V, out[15:0]}
  function automatic logic [18:0] alu_fn(input logic [1:0] op, input logic [15:0] a,
                                         input logic [15:0] b);
    logic [15:0] r;
    logic        v;
    case (op)
      2'b00:   begin r = a + b; v = (a[15] == b[15]) && (r[15] != a[15]); end
      2'b01:   begin r = a - b; v = (a[15] != b[15]) && (r[15] != a[15]); end
      2'b10:   begin r = a & b; v = 1'b0; end
      default: begin r = ~b;    v = 1'b0; end
    endcase
    return {(r == 16'h0000), r[15], v, r};
  endfunction

  function automatic logic [15:0] shf(input logic [15:0] x, input logic [1:0] s);
    logic signed [15:0] sx;
    sx = x;
    case (s)
      2'b00:   return x;
      2'b01:   return x << 1;
      2'b10:   return x >> 1;
      default: return 16'(sx >>> 1);
    endcase
  endfunction

  // External ALU responds combinationally to whatever the DUT presents
  logic [18:0] alu_resp;
  assign alu_resp = alu_fn(alu_opc, alu_ain, alu_bin);
  assign alu_out  = alu_resp[15:0];
  assign alu_z    = alu_resp[18];
  assign alu_n    = alu_resp[17];
  assign alu_v    = alu_resp[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model. Each accepted instruction is evaluated in full at the
  // handshake (the register file cannot change while it is in flight); the
  // model only tracks how many cycles ago that was, to know when each
  // externally visible value appears.
  // --------------------------------------------------------------------------
  logic [15:0] m_rf [8];
  int          m_age = 0;          // 0 = no instruction in flight
  logic [15:0] m_ain = '0, m_bin = '0, m_result = '0;
  logic [1:0]  m_opc = '0;
  logic [2:0]  m_status = '0;
  logic [15:0] p_a, p_b, p_r;
  logic [2:0]  p_st;
  logic [2:0]  p_rd;
  logic        p_cmp;

  task automatic mdl_reset();
    for (int i = 0; i < 8; i++) m_rf[i] = 16'h0;
    m_age = 0; m_ain = '0; m_bin = '0; m_result = '0; m_opc = '0; m_status = '0;
  endtask

  task automatic mdl_step();
    logic [18:0] resp;
    if (m_age == 0) begin
      if (wr_en) m_rf[wr_addr] = wr_data;
      if (instr_valid) begin
        p_a   = m_rf[rn];
        p_b   = shf(m_rf[rm], shift);
        resp  = alu_fn(alu_op, p_a, p_b);
        p_r   = resp[15:0];
        p_st  = resp[18:16];
        p_rd  = rd;
        p_cmp = cmp;
        m_opc = alu_op;
        m_age = 1;
      end
    end else begin
      m_age++;
      if (m_age == 2) m_ain = p_a;
      if (m_age == 3) m_bin = p_b;
      if (m_age == 4) begin m_result = p_r; m_status = p_st; end
      if (m_age == 5) begin
        if (!p_cmp) m_rf[p_rd] = p_r;
        m_age = 0;
      end
    end
  endtask

  // Compare process: check on the falling edge, advance the model on the rising edge
  initial begin
    mdl_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) mdl_reset();
      chk("ready",  {31'd0, instr_ready}, {31'd0, (m_age == 0)});
      chk("done",   {31'd0, done},        {31'd0, (m_age == 4)});
      chk("result", {16'd0, result},      {16'd0, m_result});
      chk("status", {29'd0, status},      {29'd0, m_status});
      chk("ain",    {16'd0, alu_ain},     {16'd0, m_ain});
      chk("bin",    {16'd0, alu_bin},     {16'd0, m_bin});
      chk("opc",    {30'd0, alu_opc},     {30'd0, m_opc});
      @(posedge clk);
      if (rst_n) mdl_step(); else mdl_reset();
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers; inputs change 1 ns after the rising edge
  // --------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    instr_valid = 1'b0;
    wr_en       = 1'b0;
    alu_op = 2'($urandom); rd = 3'($urandom); rn = 3'($urandom);
    rm = 3'($urandom); shift = 2'($urandom); cmp = 1'($urandom);
  endtask

  task automatic load(input logic [2:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  // Issue one instruction (optionally with a same-cycle load) and wait for done
  task automatic issue(input logic [1:0] op, input logic [2:0] d, input logic [2:0] n,
                       input logic [2:0] m, input logic [1:0] s, input logic c,
                       input logic we, input logic [2:0] wa, input logic [15:0] wd);
    int k;
    alu_op = op; rd = d; rn = n; rm = m; shift = s; cmp = c;
    wr_en = we; wr_addr = wa; wr_data = wd;
    instr_valid = 1'b1;
    step();
    // fields scrambled and valid held high while busy: must be ignored
    idle_inputs();
    instr_valid = 1'b1;
    k = 0;
    while (done !== 1'b1 && k < 8) begin
      step();
      k++;
    end
    instr_valid = 1'b0;
    chk("done_latency", k, 3);
  endtask

  function automatic logic [15:0] rand_data();
    case ($urandom_range(0, 5))
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      2:       return 16'hFFFF;
      3:       return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    idle_inputs();
    step();
    step();
    // Reset state, still in reset
    chk("rst_ready",  {31'd0, instr_ready}, 32'd1);
    chk("rst_done",   {31'd0, done},        32'd0);
    chk("rst_result", {16'd0, result},      32'h0);
    chk("rst_status", {29'd0, status},      32'd0);
    rst_n = 1'b1;

    // Basic ADD: 5 + 3 -> rf3 = 8
    load(3'd1, 16'h0005);
    load(3'd2, 16'h0003);
    issue(2'b00, 3'd3, 3'd1, 3'd2, 2'b00, 1'b0, 1'b0, 3'd0, 16'h0);
    chk("add_result", {16'd0, result}, 32'h0008);
    chk("add_status", {29'd0, status}, 32'd0);
    step();
    issue(2'b10, 3'd0, 3'd3, 3'd3, 2'b00, 1'b0, 1'b0, 3'd0, 16'h0);
    chk("rf3_readback", {16'd0, result}, 32'h0008);
    step();

    // Signed overflow
    load(3'd1, 16'h7FFF);
    load(3'd2, 16'h0001);
    issue(2'b00, 3'd4, 3'd1, 3'd2, 2'b00, 1'b0, 1'b0, 3'd0, 16'h0);
    chk("ovf_result", {16'd0, result}, 32'h8000);
    chk("ovf_status", {29'd0, status}, 32'd3);
    step();

    // Compare: no writeback to rd=1
    load(3'd1, 16'h1234);
    load(3'd2, 16'h1234);
    issue(2'b01, 3'd1, 3'd1, 3'd2, 2'b00, 1'b1, 1'b0, 3'd0, 16'h0);
    chk("cmp_status", {29'd0, status}, 32'd4);
    step();
    issue(2'b10, 3'd5, 3'd1, 3'd1, 2'b00, 1'b0, 1'b0, 3'd0, 16'h0);
    chk("cmp_rf1_kept", {16'd0, result}, 32'h1234);
    step();

    // Shifts on operand B
    load(3'd2, 16'h8001);
    issue(2'b11, 3'd6, 3'd0, 3'd2, 2'b11, 1'b0, 1'b0, 3'd0, 16'h0);
    chk("asr_bin",    {16'd0, alu_bin}, 32'hC000);
    chk("asr_result", {16'd0, result},  32'h3FFF);
    step();
    issue(2'b11, 3'd6, 3'd0, 3'd2, 2'b10, 1'b0, 1'b0, 3'd0, 16'h0);
    chk("lsr_bin",    {16'd0, alu_bin}, 32'h4000);
    step();

    // Same-cycle load and issue
    issue(2'b10, 3'd7, 3'd1, 3'd1, 2'b00, 1'b0, 1'b1, 3'd1, 16'h00FF);
    chk("ldiss_result", {16'd0, result}, 32'h00FF);
    step();

    // Reset in EXEC aborts the instruction
    load(3'd1, 16'h7FFF);
    load(3'd2, 16'h0001);
    issue(2'b00, 3'd4, 3'd1, 3'd2, 2'b00, 1'b0, 1'b0, 3'd0, 16'h0);
    step();
    alu_op = 2'b00; rd = 3'd5; rn = 3'd1; rm = 3'd2; shift = 2'b00; cmp = 1'b0;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    step();
    step();                          // now in EXEC
    rst_n = 1'b0;
    #1;
    chk("rexec_status", {29'd0, status}, 32'd0);
    chk("rexec_done",   {31'd0, done},   32'd0);
    step();
    chk("rexec_done2",  {31'd0, done},   32'd0);
    step();
    rst_n = 1'b1;
    chk("rexec_ready",  {31'd0, instr_ready}, 32'd1);
    issue(2'b00, 3'd0, 3'd1, 3'd2, 2'b00, 1'b0, 1'b0, 3'd0, 16'h0);
    chk("rexec_rf_clear", {16'd0, result}, 32'h0000);
    step();

    // Randomized phase
    for (int cyc = 0; cyc < 3000; cyc++) begin
      instr_valid = ($urandom_range(0, 2) != 0);
      alu_op = 2'($urandom); rd = 3'($urandom); rn = 3'($urandom);
      rm = 3'($urandom); shift = 2'($urandom); cmp = ($urandom_range(0, 3) == 0);
      wr_en = ($urandom_range(0, 2) == 0);
      wr_addr = 3'($urandom);
      wr_data = rand_data();
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
      end else begin
        step();
      end
    end

    idle_inputs();
    step();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_alu_sequencer
`default_nettype wire

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have ports instr_valid (input, 1) and instr_ready (output, 1): the instruction handshake.
REQ-004 SHALL have instruction fields as inputs: alu_op[1:0], rd[2:0], rn[2:0], rm[2:0], shift[1:0] and cmp (1; flags only, no writeback).
REQ-005 SHALL have ports wr_en (input, 1), wr_addr (input, 3) and wr_data (input, 16): external register-file load.
REQ-006 SHALL drive outputs alu_ain[15:0], alu_bin[15:0] and alu_opc[1:0] to the downstream ALU.
REQ-007 SHALL have ALU result inputs alu_out[15:0], alu_z, alu_n and alu_v (1 each).
REQ-008 SHALL have outputs result[15:0] (last ALU result), status[2:0] ({Z,N,V}) and done (1-cycle pulse).

Function
REQ-009 SHALL contain an 8 x 16-bit register file, operand registers A and B, result register C and a 3-bit status register.
REQ-010 SHALL implement states IDLE, READ_A, READ_B, EXEC and WRITE.
REQ-011 State behaviour: in IDLE, instr_ready=1; in every other state, instr_ready=0.
REQ-012 Handshake: when instr_valid and instr_ready are both 1, SHALL latch all instruction fields and move IDLE->READ_A.
REQ-013 READ_A: A <= rf[rn]; SHALL move to READ_B.
REQ-014 READ_B: B <= shift(rf[rm]); SHALL move to EXEC.
REQ-015 Shift encoding: 00 = none; 01 = LSL1 (zero fill); 10 = LSR1 (zero fill); 11 = ASR1 (replicate bit 15).
REQ-016 EXEC: alu_ain=A, alu_bin=B, alu_opc=latched alu_op; C <= alu_out; status <= {alu_z, alu_n, alu_v}; SHALL move to WRITE.
REQ-017 Outside EXEC, alu_ain, alu_bin and alu_opc SHALL hold the values of A, B and the latched op (no glitch to zero).
REQ-018 WRITE with cmp=0: rf[rd] <= C, done=1; SHALL move to IDLE.
REQ-019 WRITE with cmp=1: rf SHALL be unchanged, done=1; SHALL move to IDLE.
REQ-020 Latency: handshake at cycle 0, done at cycle 4; next instruction acceptable at cycle 5 (throughput 1 instruction per 5 cycles).
REQ-021 result SHALL equal C; status SHALL change only in EXEC.
REQ-022 External load: wr_en=1 in IDLE writes rf[wr_addr] <= wr_data; wr_en SHALL be ignored in all other states.
REQ-023 Simultaneous wr_en and handshake in IDLE: both take effect; READ_A/READ_B SHALL read the newly written value.
REQ-024 rd equal to rn or rm SHALL be legal; the operands already captured in A and B are unaffected by the writeback.
REQ-025 instr_valid while instr_ready=0 SHALL be ignored; field inputs are sampled only at the handshake.

Reset
REQ-026 rst_n=0 SHALL immediately force: state=IDLE, A=B=C=0, status=3'b000, done=0, latched op=00, and all rf entries=0.
REQ-027 Reset asserted mid-instruction SHALL abort it: no writeback, no done pulse.
REQ-028 The first handshake SHALL be possible on the first rising edge with rst_n=1.

Structure
REQ-029 Package alu_seq_pkg SHALL hold the state enum, shift-code constants, ALU op constants (ADD=00, SUB=01, AND=10, NOTB=11) and REG_W=16.
REQ-030 The barrel-lite shifter SHALL be a separate combinational sub-module, shifter16.
REQ-031 The FSM, register file and operand registers SHALL remain in alu_sequencer.
REQ-032 The ALU SHALL be external, connected via the REQ-006/REQ-007 ports.

Verification
REQ-033 Basic ADD: rf1=0x0005, rf2=0x0003, ADD rd=3 rn=1 rm=2 shift=00 -> done at cycle 4, rf3=0x0008, status=000.
REQ-034 Signed overflow: rf1=0x7FFF, rf2=0x0001, ADD -> result=0x8000, status=011 (N=1, V=1).
REQ-035 Compare, no writeback: rf1=rf2=0x1234, SUB cmp=1 rd=1 -> status=100, rf1 still 0x1234, done pulses.
REQ-036 Shifts: rf2=0x8001 with NOTB shift=11 -> B=0xC000, result=0x3FFF; with shift=10 -> B=0x4000.
REQ-037 Same-cycle load and issue: in IDLE, wr_en to rf1=0x00FF together with AND rn=1 rm=1 -> result=0x00FF.
REQ-038 Reset in EXEC: assert rst_n=0 -> status=000, done never pulses, instr_ready=1 after release.
